// File: rtl/bip_result_framer_pkg.sv
// Shared constants for the BIP result framer: default widths, frame header
// byte and the transmit FSM state encoding.
package bip_result_framer_pkg;

  localparam int DEF_NB_INSTRUCTION = 16;
  localparam int DEF_NB_ADDR        = 11;
  localparam int DEF_NB_DATA        = 8;

  localparam logic [7:0] DEF_FRAME_HEADER = 8'hA5;

  // Encoding is shared with the host-side command receiver; keep values fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } framer_state_e;

  function automatic int bytes_for(input int nb_bits, input int nb_byte);
    return (nb_bits + nb_byte - 1) / nb_byte;
  endfunction

endpackage

// File: rtl/bip_result_framer_if.sv
// Signal bundle between the BIP core / UART transmitter and the result framer.
// The framer uses the slave view; the surrounding top level uses master.
interface bip_result_framer_if
  import bip_result_framer_pkg::*;
#(
  parameter int NB_INSTRUCTION = DEF_NB_INSTRUCTION,
  parameter int NB_ADDR        = DEF_NB_ADDR,
  parameter int NB_DATA        = DEF_NB_DATA
);

  logic                      i_program_done;
  logic [NB_ADDR-1:0]        i_program_counter;
  logic [NB_INSTRUCTION-1:0] i_accumulator;
  logic                      i_tx_done;
  logic                      o_tx_start;
  logic [NB_DATA-1:0]        o_tx_data;
  logic                      o_busy;
  logic                      o_overrun;

  modport slave (
    input  i_program_done,
    input  i_program_counter,
    input  i_accumulator,
    input  i_tx_done,
    output o_tx_start,
    output o_tx_data,
    output o_busy,
    output o_overrun
  );

  modport master (
    output i_program_done,
    output i_program_counter,
    output i_accumulator,
    output i_tx_done,
    input  o_tx_start,
    input  o_tx_data,
    input  o_busy,
    input  o_overrun
  );

endinterface

// File: rtl/bip_result_framer_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse on the first cycle a level
// input is seen high, however long it then stays high.
module bip_result_framer_rise_detect
  import bip_result_framer_pkg::*;
(
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_d;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_d;

endmodule

// File: rtl/bip_result_framer.sv
// Frames the BIP final PC and ACC as header, PC bytes, ACC bytes, XOR checksum
// and hands them to the UART one byte at a time with a start/done handshake.
module bip_result_framer
  import bip_result_framer_pkg::*;
#(
  parameter int                  NB_INSTRUCTION = DEF_NB_INSTRUCTION,
  parameter int                  NB_ADDR        = DEF_NB_ADDR,
  parameter int                  NB_DATA        = DEF_NB_DATA,
  parameter logic [NB_DATA-1:0]  FRAME_HEADER   = NB_DATA'(DEF_FRAME_HEADER)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  bip_result_framer_if.slave   bus
);

  localparam int NB_PC_BYTES  = bytes_for(NB_ADDR, NB_DATA);
  localparam int NB_ACC_BYTES = bytes_for(NB_INSTRUCTION, NB_DATA);
  localparam int NB_FRAME     = 1 + NB_PC_BYTES + NB_ACC_BYTES + 1;
  localparam int NB_PC_W      = NB_PC_BYTES * NB_DATA;
  localparam int NB_ACC_W     = NB_ACC_BYTES * NB_DATA;
  localparam int NB_PAYLOAD_W = (NB_FRAME - 1) * NB_DATA;
  localparam int IDX_W        = $clog2(NB_FRAME);
  localparam int NB_SLOTS     = 1 << IDX_W;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_FRAME - 1);

  framer_state_e             r_state;
  framer_state_e             w_state_next;
  logic [IDX_W-1:0]          r_index;
  logic [IDX_W-1:0]          w_index_next;
  logic [NB_ADDR-1:0]        r_pc_snap;
  logic [NB_ADDR-1:0]        w_pc_snap_next;
  logic [NB_INSTRUCTION-1:0] r_acc_snap;
  logic [NB_INSTRUCTION-1:0] w_acc_snap_next;
  logic [NB_DATA-1:0]        r_checksum;
  logic [NB_DATA-1:0]        w_checksum_next;
  logic                      r_overrun;
  logic                      w_overrun_next;

  logic                      w_trigger;
  logic                      w_tx_start;
  logic                      w_busy;
  logic [NB_PAYLOAD_W-1:0]   w_payload;
  logic [NB_DATA-1:0]        w_bytes [NB_SLOTS];
  logic [NB_DATA-1:0]        w_cur_byte;

  bip_result_framer_rise_detect u_done_rise (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (bus.i_program_done),
    .o_rise  (w_trigger)
  );

  // Fields are zero-extended to whole bytes and sent MSB byte first.
  assign w_payload = {FRAME_HEADER, NB_PC_W'(r_pc_snap), NB_ACC_W'(r_acc_snap)};

  genvar gi;
  generate
    for (gi = 0; gi < NB_FRAME - 1; gi++) begin : g_payload_bytes
      assign w_bytes[gi] = w_payload[(NB_FRAME - 1 - gi) * NB_DATA - 1 -: NB_DATA];
    end
    for (gi = NB_FRAME; gi < NB_SLOTS; gi++) begin : g_unused_slots
      assign w_bytes[gi] = '0;
    end
  endgenerate

  assign w_bytes[NB_FRAME-1] = r_checksum;
  assign w_cur_byte          = w_bytes[r_index];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_pc_snap  <= '0;
      r_acc_snap <= '0;
      r_checksum <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_index    <= w_index_next;
      r_pc_snap  <= w_pc_snap_next;
      r_acc_snap <= w_acc_snap_next;
      r_checksum <= w_checksum_next;
      r_overrun  <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_index_next    = r_index;
    w_pc_snap_next  = r_pc_snap;
    w_acc_snap_next = r_acc_snap;
    w_checksum_next = r_checksum;
    w_tx_start      = 1'b0;
    // Any trigger outside IDLE is lost, including one coinciding with the last done.
    w_overrun_next  = r_overrun | (w_trigger & (r_state != ST_IDLE));

    case (r_state)
      ST_IDLE: begin
        if (w_trigger) begin
          w_pc_snap_next  = bus.i_program_counter;
          w_acc_snap_next = bus.i_accumulator;
          w_index_next    = '0;
          w_checksum_next = '0;
          w_state_next    = ST_START;
        end
      end
      ST_START: begin
        w_tx_start = 1'b1;
        // The checksum byte itself must not fold into the running XOR.
        if (r_index != LAST_IDX) begin
          w_checksum_next = r_checksum ^ w_cur_byte;
        end
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (r_index == LAST_IDX) begin
            w_state_next = ST_IDLE;
          end else begin
            w_index_next = r_index + IDX_W'(1);
            w_state_next = ST_START;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign w_busy         = (r_state != ST_IDLE);
  assign bus.o_tx_start = w_tx_start;
  assign bus.o_tx_data  = w_busy ? w_cur_byte : '0;
  assign bus.o_busy     = w_busy;
  assign bus.o_overrun  = r_overrun;

endmodule

// File: tb/tb_bip_result_framer.sv
// Self-checking bench for bip_result_framer: table of PC/ACC frames through a
// byte scoreboard, plus hold-high, overrun, reset, input-churn and stray-done cases.
module tb_bip_result_framer;

  localparam int NB_I = 16;
  localparam int NB_A = 11;
  localparam int NB_D = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  bip_result_framer_if #(.NB_INSTRUCTION(NB_I), .NB_ADDR(NB_A), .NB_DATA(NB_D)) bus ();

  bip_result_framer #(.NB_INSTRUCTION(NB_I), .NB_ADDR(NB_A), .NB_DATA(NB_D)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [10:0] pc;
    logic [15:0] acc;
    logic [47:0] frame;
  } vec_t;

  vec_t       vecs [5];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q [$];
  int         start_count = 0;
  int         uart_dly = 3;
  bit         idle_stray = 0;
  bit         stray_in_start = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name, input int budget);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no response within %0d cycles (t=%0t)", name, budget, $time);
  endtask

  task automatic push_frame(input logic [47:0] f);
    logic [47:0] fr;
    fr = f;
    for (int i = 0; i < 6; i++) exp_q.push_back(fr[47-8*i -: 8]);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (bus.o_busy === 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.o_busy !== 1'b0) timeout_fail(name, budget);
  endtask

  task automatic wait_starts(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (start_count < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (start_count < target) timeout_fail(name, budget);
  endtask

  // Drives a trigger with the given PC/ACC and checks one-cycle start latency.
  task automatic trigger(input logic [10:0] pc, input logic [15:0] acc, input logic [47:0] f, input bit hold);
    @(negedge clk);
    bus.i_program_counter = pc;
    bus.i_accumulator     = acc;
    bus.i_program_done    = 1'b1;
    push_frame(f);
    @(posedge clk); #1;
    check("latency_start", {31'd0, bus.o_tx_start}, 32'd1);
    check("busy_rise", {31'd0, bus.o_busy}, 32'd1);
    if (!hold) begin
      @(negedge clk);
      bus.i_program_done = 1'b0;
    end
  endtask

  // Scoreboard: every o_tx_start pops the next expected byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && bus.o_tx_start === 1'b1) begin
        start_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_start: got byte 0x%0h, expected no start (t=%0t)", bus.o_tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, e});
        end
      end
    end
  end

  // UART model: answers each start with a done pulse uart_dly cycles later.
  initial begin
    int cnt;
    cnt = 0;
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (idle_stray) begin
        bus.i_tx_done = 1'b1;
        idle_stray    = 1'b0;
      end else if (bus.o_tx_start === 1'b1) begin
        cnt = uart_dly;
        if (stray_in_start) bus.i_tx_done = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.i_tx_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    vecs[0] = '{pc: 11'h07F, acc: 16'h1234, frame: 48'hA5_00_7F_12_34_FC};
    vecs[1] = '{pc: 11'h7FF, acc: 16'hFFFF, frame: 48'hA5_07_FF_FF_FF_5D};
    vecs[2] = '{pc: 11'h000, acc: 16'h0000, frame: 48'hA5_00_00_00_00_A5};
    vecs[3] = '{pc: 11'h400, acc: 16'h8001, frame: 48'hA5_04_00_80_01_20};
    vecs[4] = '{pc: 11'h123, acc: 16'hBEEF, frame: 48'hA5_01_23_BE_EF_D6};

    bus.i_program_done    = 1'b0;
    bus.i_program_counter = '0;
    bus.i_accumulator     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_overrun", {31'd0, bus.o_overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      base = start_count;
      trigger(vecs[v].pc, vecs[v].acc, vecs[v].frame, 1'b0);
      wait_idle(200, "tbl_idle");
      check("tbl_start_count", start_count - base, 32'd6);
      check("tbl_queue_drained", exp_q.size(), 32'd0);
      check("tbl_overrun", {31'd0, bus.o_overrun}, 32'd0);
      check("tbl_idle_data", {24'd0, bus.o_tx_data}, 32'd0);
      $display("frame %0d: pc=0x%0h acc=0x%0h sent", v, vecs[v].pc, vecs[v].acc);
    end

    // Done held high long after the frame: exactly one frame
    base = start_count;
    trigger(vecs[0].pc, vecs[0].acc, vecs[0].frame, 1'b1);
    wait_idle(200, "hold_idle");
    repeat (10000) @(posedge clk);
    #1;
    check("hold_start_count", start_count - base, 32'd6);
    check("hold_overrun", {31'd0, bus.o_overrun}, 32'd0);
    check("hold_busy", {31'd0, bus.o_busy}, 32'd0);
    @(negedge clk);
    bus.i_program_done = 1'b0;
    repeat (3) @(negedge clk);
    $display("hold-high: one frame only");

    // Second trigger during byte2 WAIT: dropped, overrun set
    base = start_count;
    trigger(vecs[0].pc, vecs[0].acc, vecs[0].frame, 1'b0);
    wait_starts(base + 3, 200, "ovr_byte2");
    @(negedge clk);
    @(negedge clk);
    bus.i_program_counter = 11'h555;
    bus.i_accumulator     = 16'hAAAA;
    bus.i_program_done    = 1'b1;
    @(negedge clk);
    bus.i_program_done = 1'b0;
    @(posedge clk); #1;
    check("ovr_set", {31'd0, bus.o_overrun}, 32'd1);
    check("ovr_busy", {31'd0, bus.o_busy}, 32'd1);
    wait_idle(200, "ovr_idle");
    repeat (20) @(posedge clk);
    #1;
    check("ovr_start_count", start_count - base, 32'd6);
    check("ovr_queue_drained", exp_q.size(), 32'd0);
    check("ovr_sticky", {31'd0, bus.o_overrun}, 32'd1);
    $display("overrun: frame intact, overrun latched");

    // Reset during byte3 WAIT aborts at once; next frame is complete
    base = start_count;
    trigger(vecs[3].pc, vecs[3].acc, vecs[3].frame, 1'b0);
    wait_starts(base + 4, 200, "rst_byte3");
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_start", {31'd0, bus.o_tx_start}, 32'd0);
    check("midrst_tx_data", {24'd0, bus.o_tx_data}, 32'd0);
    check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("midrst_overrun", {31'd0, bus.o_overrun}, 32'd0);
    exp_q.delete();
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    base = start_count;
    trigger(vecs[4].pc, vecs[4].acc, vecs[4].frame, 1'b0);
    wait_idle(200, "postrst_idle");
    check("postrst_start_count", start_count - base, 32'd6);
    check("postrst_queue_drained", exp_q.size(), 32'd0);
    $display("mid-frame reset: aborted, next frame complete");

    // PC/ACC churn after trigger must not reach the frame
    base = start_count;
    @(negedge clk);
    bus.i_program_counter = vecs[1].pc;
    bus.i_accumulator     = vecs[1].acc;
    bus.i_program_done    = 1'b1;
    push_frame(vecs[1].frame);
    n = 0;
    do begin
      @(negedge clk);
      bus.i_program_done    = 1'b0;
      bus.i_program_counter = 11'($urandom);
      bus.i_accumulator     = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end while (bus.o_busy === 1'b1 && n < 200);
    if (bus.o_busy !== 1'b0) timeout_fail("churn_idle", 200);
    check("churn_start_count", start_count - base, 32'd6);
    check("churn_queue_drained", exp_q.size(), 32'd0);
    $display("input churn: snapshot held");

    // Stray done in IDLE and in every START cycle
    base = start_count;
    @(negedge clk);
    idle_stray = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stray_idle_busy", {31'd0, bus.o_busy}, 32'd0);
    check("stray_idle_starts", start_count - base, 32'd0);
    stray_in_start = 1'b1;
    trigger(vecs[2].pc, vecs[2].acc, vecs[2].frame, 1'b0);
    wait_idle(200, "stray_idle");
    stray_in_start = 1'b0;
    check("stray_start_count", start_count - base, 32'd6);
    check("stray_queue_drained", exp_q.size(), 32'd0);
    $display("stray done: ignored");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
